ysyx_22041207_mdu_ctrl: RTL and testbench
=========================================

Name: ysyx_22041207_mdu_ctrl

Overview:
- Sequencer for the execute stage's multi-cycle M-extension units: one multiplier and one divider, both with valid/ready/out_valid handshakes.
- Accepts one RV64M operation at a time from EX and stalls EX while a unit is busy.
- Drives operands and signedness to the selected unit, waits for its result, then selects, word-truncates and sign-extends the result.
- Handles pipeline flush and RISC-V divide special cases.

Parameters:
- XLEN, 64, operand/result width
- DIV_TIMEOUT, 255, max cycles in DIV_WAIT before forced abort (0 = no timeout)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  kill in-flight op (branch/trap)
- ex_valid  in  1  EX presents an M op; held until res_valid
- ex_op  in  4  [2:0]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; [3]: word (*W) variant
- ex_a  in  XLEN  rs1 value
- ex_b  in  XLEN  rs2 value
- stall  out  1  EX must hold
- res  out  XLEN  result, valid with res_valid
- res_valid  out  1  one-cycle result pulse
- mul_valid  out  1  multiplier start pulse
- mul_flush  out  1  multiplier abort pulse
- mul_sign  out  2  {a_signed, b_signed}
- mul_a, mul_b  out  XLEN  multiplier operands
- mul_ready  in  1  multiplier idle
- mul_out_valid  in  1  multiplier result strobe
- mul_hi, mul_lo  in  XLEN  128-bit product halves
- div_valid  out  1  divider start pulse
- div_flush  out  1  divider abort pulse
- div_signed  out  1  signed divide
- div_a, div_b  out  XLEN  dividend, divisor
- div_ready  in  1  divider idle
- div_out_valid  in  1  divider result strobe
- div_quot, div_rem  in  XLEN  quotient, remainder

Behaviour:
- Reset (async): state IDLE; res=0; res_valid, mul_valid, div_valid, mul_flush, div_flush = 0; operand regs = 0.
- States: IDLE, MUL_REQ, MUL_WAIT, DIV_REQ, DIV_WAIT, DONE.
- Operand prep at accept, registered:
  - Word ops: operands are low 32 bits, sign- or zero-extended to XLEN per op signedness.
  - Signedness: MUL/MULH/DIV/REM signed both; MULHSU {1,0}; MULHU/DIVU/REMU unsigned.
- IDLE, ex_valid=1, no flush:
  - op[2]=0 -> MUL_REQ.
  - op[2]=1 -> special check (see Optional Feature), else DIV_REQ.
- MUL_REQ / DIV_REQ:
  - Wait for unit ready.
  - In the cycle ready=1: assert valid for exactly that cycle, go to *_WAIT.
- MUL_WAIT: on mul_out_valid, capture the result and go to DONE.
  - MUL, MULW: mul_lo, with MULW = sext(mul_lo[31:0]).
  - MULH, MULHSU, MULHU: mul_hi.
- DIV_WAIT: on div_out_valid, capture the result and go to DONE.
  - DIV*: div_quot; REM*: div_rem.
  - Word variants sign-extend bit 31.
- DIV_WAIT timeout: if DIV_TIMEOUT≠0 and the counter reaches DIV_TIMEOUT, pulse div_flush, return res=all-ones, go to DONE.
- DONE: res_valid=1 for one cycle, stall=0, then IDLE.
  - EX must drop or replace ex_valid in the same cycle.
  - A new op is accepted no earlier than the next IDLE cycle.
- stall = ex_valid & (state≠DONE). Combinational, so it is high in the accept cycle.
- Latency, unit with ready=1 and result k cycles after start: accept T, valid T+1, res_valid T+2+k.
- flush, any state: next state IDLE, no res_valid.
  - In *_WAIT: pulse the matching *_flush for one cycle; a same-cycle out_valid is discarded.
  - In *_REQ: valid is not asserted.
  - flush wins over every simultaneous event.
- mul_valid and div_valid are never both high. Never re-issued without a new accept.

Optional Feature:
- Macro: YSYX_22041207_MDU_SPECIAL_EN.
- Defined: divide special cases, after operand prep, resolve in IDLE directly to DONE with no divider start.
  - b=0: DIV/DIVU = all-ones, REM/REMU = a.
  - Signed overflow (a=most-negative, b=-1): DIV = a, REM = 0.
  - Word variants use 32-bit rules, then sign-extend.
- Undefined: all divide ops go to the divider unchanged; the divider is responsible for these results.

Test Plan:
- MUL, a=3, b=-5, mul_ready=1, product after 4 cycles -> mul_valid once, mul_sign=2'b11, res=0xFFFF_FFFF_FFFF_FFF1, res_valid 6 cycles after accept, stall high until then.
- MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF, mul_ready low 3 cycles -> mul_valid only after ready, mul_sign=00, res=0xFFFF_FFFF_FFFF_FFFE.
- DIVW, a=0x0000_0000_8000_0000, b=0xFFFF_FFFF, feature on -> no div_valid, res=0xFFFF_FFFF_8000_0000 at T+1. Feature off -> div_valid issued, divider output passed through sign-extended.
- REMU, b=0, feature on -> res=a. DIVU, a=100, b=7, feature off -> res=14 from div_quot.
- flush 2 cycles into DIV_WAIT -> div_flush pulse, no res_valid, next op accepted the cycle after IDLE.
- rst asserted mid MUL_WAIT -> all outputs 0 immediately, state IDLE; a late mul_out_valid is ignored.

Source files
------------

// File: rtl/ysyx_22041207_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22041207_mdu_ctrl
//
// Purpose:
//   Sequencer between the execute stage and the multi-cycle RV64M units.
//   Accepts one multiply/divide op at a time from EX and holds EX stalled
//   while the selected unit works. It drives registered operands and
//   signedness to the unit, waits for the result strobe, then selects,
//   word-truncates and sign-extends the result. The block also handles
//   pipeline flush and an optional divider timeout.
//
// Optional feature (macro YSYX_22041207_MDU_SPECIAL_EN):
//   When the macro is defined, divide-by-zero and signed overflow resolve
//   in IDLE straight to DONE and the divider is never started.
//   When it is undefined, every divide goes to the divider unchanged.
//
// Parameters:
//   XLEN         operand/result width (>= 32)
//   DIV_TIMEOUT  counter value in DIV_WAIT that forces an abort (0 = never)
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   flush                          kill the in-flight op
//   ex_valid/ex_op/ex_a/ex_b       op request from EX (held until res_valid)
//   stall                          EX must hold
//   res/res_valid                  result and its one-cycle pulse
//   mul_valid/mul_flush/mul_sign   multiplier start, abort, {a_signed,b_signed}
//   mul_a/mul_b                    multiplier operands
//   mul_ready/mul_out_valid        multiplier idle, result strobe
//   mul_hi/mul_lo                  128-bit product halves
//   div_valid/div_flush/div_signed divider start, abort, signed divide
//   div_a/div_b                    dividend, divisor
//   div_ready/div_out_valid        divider idle, result strobe
//   div_quot/div_rem               quotient, remainder
// ---------------------------------------------------------------------------
module ysyx_22041207_mdu_ctrl #(
  parameter int XLEN        = 64,
  parameter int DIV_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [3:0]      ex_op,
  input  logic [XLEN-1:0] ex_a,
  input  logic [XLEN-1:0] ex_b,
  output logic            stall,
  output logic [XLEN-1:0] res,
  output logic            res_valid,
  output logic            mul_valid,
  output logic            mul_flush,
  output logic [1:0]      mul_sign,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic            mul_ready,
  input  logic            mul_out_valid,
  input  logic [XLEN-1:0] mul_hi,
  input  logic [XLEN-1:0] mul_lo,
  output logic            div_valid,
  output logic            div_flush,
  output logic            div_signed,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic            div_ready,
  input  logic            div_out_valid,
  input  logic [XLEN-1:0] div_quot,
  input  logic [XLEN-1:0] div_rem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_REQ,
    S_MUL_WAIT,
    S_DIV_REQ,
    S_DIV_WAIT,
    S_DONE
  } state_t;

  localparam int CW = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT + 1) : 1;

  state_t          r_state;
  logic [1:0]      r_opSel;
  logic            r_word;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [1:0]      r_mulSign;
  logic            r_divSigned;
  logic [XLEN-1:0] r_res;
  logic [CW-1:0]   r_divCnt;

  logic [2:0]      w_opc;
  logic            w_word;
  logic            w_aSigned;
  logic            w_bSigned;
  logic [XLEN-1:0] w_aPrep;
  logic [XLEN-1:0] w_bPrep;
  logic [XLEN-1:0] w_mulRes;
  logic [XLEN-1:0] w_divRes;
  logic            w_timeout;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic s);
    return s ? sext32(v) : {{(XLEN-32){1'b0}}, v[31:0]};
  endfunction

  // Operand preparation: decode signedness from the op and, for *W ops,
  // narrow the operands to 32 bits and extend them according to that
  // signedness. The units then always see full-width operands.
  always_comb begin
    w_opc     = ex_op[2:0];
    w_word    = ex_op[3];
    w_aSigned = 1'b0;
    w_bSigned = 1'b0;
    case (w_opc)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        w_aSigned = 1'b1;
        w_bSigned = 1'b1;
      end
      3'd2: begin
        w_aSigned = 1'b1;
        w_bSigned = 1'b0;
      end
      default: begin
        w_aSigned = 1'b0;
        w_bSigned = 1'b0;
      end
    endcase
    w_aPrep = w_word ? ext32(ex_a, w_aSigned) : ex_a;
    w_bPrep = w_word ? ext32(ex_b, w_bSigned) : ex_b;
  end

  // Result selection from the unit outputs. Only MUL/MULW take the low
  // product half; word variants always sign-extend bit 31.
  always_comb begin
    w_mulRes = (r_opSel == 2'b00) ? mul_lo : mul_hi;
    if (r_word) begin
      w_mulRes = sext32(w_mulRes);
    end
    w_divRes = r_opSel[1] ? div_rem : div_quot;
    if (r_word) begin
      w_divRes = sext32(w_divRes);
    end
  end

`ifdef YSYX_22041207_MDU_SPECIAL_EN
  logic            w_bZero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_mostNeg;
  logic [XLEN-1:0] w_specRes;

  // Divide special cases, evaluated on the prepared operands. Because word
  // operands are already sign-extended, the 32-bit most-negative value shows
  // up as XLEN-31 ones followed by 31 zeros, and -1 is all ones either way.
  always_comb begin
    w_mostNeg = w_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}}
                       : {1'b1, {(XLEN-1){1'b0}}};
    w_bZero   = (w_bPrep == '0);
    w_ovf     = ~w_opc[0] & (w_aPrep == w_mostNeg) & (w_bPrep == '1);
    w_special = w_opc[2] & (w_bZero | w_ovf);
    if (w_bZero) begin
      w_specRes = w_opc[1] ? w_aPrep : '1;
    end else begin
      w_specRes = w_opc[1] ? '0 : w_aPrep;
    end
    if (w_word) begin
      w_specRes = sext32(w_specRes);
    end
  end
`endif

  assign w_timeout = (DIV_TIMEOUT != 0) && (r_divCnt == CW'(DIV_TIMEOUT));

  // Main sequencer. Flush is tested first in every busy state so that it
  // wins over ready, out_valid and the timeout arriving in the same cycle.
  // A result strobe in the timeout cycle is preferred over aborting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_opSel     <= 2'b00;
      r_word      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_mulSign   <= 2'b00;
      r_divSigned <= 1'b0;
      r_res       <= '0;
      r_divCnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ex_valid && !flush) begin
            r_opSel     <= w_opc[1:0];
            r_word      <= w_word;
            r_a         <= w_aPrep;
            r_b         <= w_bPrep;
            r_mulSign   <= {w_aSigned, w_bSigned};
            r_divSigned <= ~w_opc[0];
            if (!w_opc[2]) begin
              r_state <= S_MUL_REQ;
            end else begin
`ifdef YSYX_22041207_MDU_SPECIAL_EN
              if (w_special) begin
                r_res   <= w_specRes;
                r_state <= S_DONE;
              end else begin
                r_state <= S_DIV_REQ;
              end
`else
              r_state <= S_DIV_REQ;
`endif
            end
          end
        end
        S_MUL_REQ: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (mul_ready) begin
            r_state <= S_MUL_WAIT;
          end
        end
        S_MUL_WAIT: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (mul_out_valid) begin
            r_res   <= w_mulRes;
            r_state <= S_DONE;
          end
        end
        S_DIV_REQ: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (div_ready) begin
            r_divCnt <= '0;
            r_state  <= S_DIV_WAIT;
          end
        end
        S_DIV_WAIT: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (div_out_valid) begin
            r_res   <= w_divRes;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_res   <= '1;
            r_state <= S_DONE;
          end else begin
            r_divCnt <= r_divCnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake strobes are decoded from the state so that a start pulse
  // lines up with the cycle the unit reports ready, and a flush in the
  // same cycle suppresses both starts and the result pulse.
  assign stall      = ex_valid & (r_state != S_DONE);
  assign res_valid  = (r_state == S_DONE) & ~flush;
  assign res        = r_res;
  assign mul_valid  = (r_state == S_MUL_REQ) & mul_ready & ~flush;
  assign div_valid  = (r_state == S_DIV_REQ) & div_ready & ~flush;
  assign mul_flush  = (r_state == S_MUL_WAIT) & flush;
  assign div_flush  = (r_state == S_DIV_WAIT) & (flush | (w_timeout & ~div_out_valid));
  assign mul_sign   = r_mulSign;
  assign mul_a      = r_a;
  assign mul_b      = r_b;
  assign div_signed = r_divSigned;
  assign div_a      = r_a;
  assign div_b      = r_b;

endmodule

// File: tb/tb_ysyx_22041207_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041207_mdu_ctrl
//
// Scoreboard bench for the RV64M sequencer. The stimulus driver pushes the
// architectural result of each op into a queue; a monitor pops and compares
// whenever res_valid is seen. Multiplier and divider are behavioural models
// with programmable ready delay and latency. The special-case expectations
// follow YSYX_22041207_MDU_SPECIAL_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_ysyx_22041207_mdu_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [63:0] ex_a;
  logic [63:0] ex_b;
  logic        stall;
  logic [63:0] res;
  logic        res_valid;
  logic        mul_valid;
  logic        mul_flush;
  logic [1:0]  mul_sign;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic        mul_ready;
  logic        mul_out_valid;
  logic [63:0] mul_hi;
  logic [63:0] mul_lo;
  logic        div_valid;
  logic        div_flush;
  logic        div_signed;
  logic [63:0] div_a;
  logic [63:0] div_b;
  logic        div_ready;
  logic        div_out_valid;
  logic [63:0] div_quot;
  logic [63:0] div_rem;

  int          checks = 0;
  int          errors = 0;
  int          mulLat = 1;
  int          divLat = 1;
  logic [63:0] expQ[$];

  ysyx_22041207_mdu_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
    .stall(stall), .res(res), .res_valid(res_valid),
    .mul_valid(mul_valid), .mul_flush(mul_flush), .mul_sign(mul_sign),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready),
    .mul_out_valid(mul_out_valid), .mul_hi(mul_hi), .mul_lo(mul_lo),
    .div_valid(div_valid), .div_flush(div_flush), .div_signed(div_signed),
    .div_a(div_a), .div_b(div_b), .div_ready(div_ready),
    .div_out_valid(div_out_valid), .div_quot(div_quot), .div_rem(div_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural RV64M result computed with plain arithmetic.
  function automatic logic [63:0] refModel(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  a32;
    logic [31:0]  b32;
    logic [31:0]  r32;
    logic [63:0]  r;
    a32 = a[31:0];
    b32 = b[31:0];
    r   = '0;
    r32 = '0;
    p   = '0;
    if (op[3]) begin
      case (op[2:0])
        3'd0: r32 = a32 * b32;
        3'd4: begin
          if (b32 == 0) r32 = '1;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
          else r32 = $signed(a32) / $signed(b32);
        end
        3'd5: begin
          if (b32 == 0) r32 = '1;
          else r32 = a32 / b32;
        end
        3'd6: begin
          if (b32 == 0) r32 = a32;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = '0;
          else r32 = $signed(a32) % $signed(b32);
        end
        default: begin
          if (b32 == 0) r32 = a32;
          else r32 = a32 % b32;
        end
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (op[2:0])
        3'd0: r = a * b;
        3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
        3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
        3'd3: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
        3'd4: begin
          if (b == 0) r = '1;
          else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
          else r = $signed(a) / $signed(b);
        end
        3'd5: begin
          if (b == 0) r = '1;
          else r = a / b;
        end
        3'd6: begin
          if (b == 0) r = a;
          else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
          else r = $signed(a) % $signed(b);
        end
        default: begin
          if (b == 0) r = a;
          else r = a % b;
        end
      endcase
    end
    return r;
  endfunction

  function automatic bit specialCase(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bit s;
    s = 1'b0;
`ifdef YSYX_22041207_MDU_SPECIAL_EN
    if (op[2]) begin
      if (op[3]) begin
        s = (b[31:0] == 0) ||
            (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      end else begin
        s = (b == 0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
      end
    end
`endif
    return s;
  endfunction

  // Multiplier model: starts on mul_valid, answers mulLat cycles later.
  initial begin : mulModel
    int           pend;
    logic [127:0] p;
    pend = 0;
    p = '0;
    mul_out_valid = 1'b0;
    mul_hi = '0;
    mul_lo = '0;
    forever begin
      @(negedge clk);
      mul_out_valid = 1'b0;
      if (mul_flush) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mul_out_valid = 1'b1;
          mul_hi = p[127:64];
          mul_lo = p[63:0];
        end
      end
      if (mul_valid) begin
        p = {{64{mul_sign[1] & mul_a[63]}}, mul_a} * {{64{mul_sign[0] & mul_b[63]}}, mul_b};
        pend = mulLat;
      end
    end
  end

  // Divider model with RISC-V semantics; divLat = 0 means it never answers.
  initial begin : divModel
    int          pend;
    logic [63:0] q;
    logic [63:0] r;
    pend = 0;
    q = '0;
    r = '0;
    div_out_valid = 1'b0;
    div_quot = '0;
    div_rem = '0;
    forever begin
      @(negedge clk);
      div_out_valid = 1'b0;
      if (div_flush) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          div_out_valid = 1'b1;
          div_quot = q;
          div_rem = r;
        end
      end
      if (div_valid) begin
        if (div_b == 0) begin
          q = '1;
          r = div_a;
        end else if (div_signed && div_a == 64'h8000_0000_0000_0000 && div_b == '1) begin
          q = div_a;
          r = '0;
        end else if (div_signed) begin
          q = $signed(div_a) / $signed(div_b);
          r = $signed(div_a) % $signed(div_b);
        end else begin
          q = div_a / div_b;
          r = div_a % div_b;
        end
        pend = divLat;
      end
    end
  end

  // Scoreboard monitor: every result pulse must match the oldest expectation.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (res_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected res_valid", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("res value", res, e);
        end
      end
      if (mul_valid && div_valid) begin
        checkOutput("mul_valid/div_valid overlap", 64'd1, 64'd0);
      end
    end
  end

  // Issue one op, hold ex_valid until the result pulse, and check the
  // handshake profile. k = 0 on a divide exercises the timeout path.
  task automatic applyStimulus(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                               input int d, input int k);
    bit          isDiv;
    bit          spec;
    bit          toPath;
    bit          done;
    bit          stallOk;
    int          n;
    int          nMul;
    int          nDiv;
    int          nFlush;
    int          expLat;
    logic [1:0]  sgn;
    logic [1:0]  expSgn;
    logic [63:0] e;
    isDiv  = op[2];
    spec   = specialCase(op, a, b);
    toPath = isDiv && !spec && (k == 0);
    e      = toPath ? 64'hFFFF_FFFF_FFFF_FFFF : refModel(op, a, b);
    expLat = spec ? 1 : (toPath ? -1 : 2 + d + k);
    case (op[1:0])
      2'd0, 2'd1: expSgn = 2'b11;
      2'd2:       expSgn = 2'b10;
      default:    expSgn = 2'b00;
    endcase
    expQ.push_back(e);
    mulLat = k;
    divLat = k;
    @(posedge clk);
    #1;
    mul_ready = 1'b0;
    div_ready = 1'b0;
    ex_valid  = 1'b1;
    ex_op     = op;
    ex_a      = a;
    ex_b      = b;
    n = 0; nMul = 0; nDiv = 0; nFlush = 0;
    done = 1'b0; stallOk = 1'b1; sgn = 2'bxx;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
      if (mul_valid) begin nMul++; sgn = mul_sign; end
      if (div_valid) nDiv++;
      if (mul_flush || div_flush) nFlush++;
      if (res_valid) begin
        done = 1'b1;
        if (stall) stallOk = 1'b0;
      end else begin
        if (!stall) stallOk = 1'b0;
        @(posedge clk);
        #1;
        if (n == d + 1) begin
          mul_ready = 1'b1;
          div_ready = 1'b1;
        end
      end
    end
    if (!done) begin
      checkOutput("res_valid wait bound", 64'd0, 64'd1);
      void'(expQ.pop_back());
    end else begin
      if (expLat >= 0) checkOutput("latency", 64'(n - 1), 64'(expLat));
      checkOutput("stall profile", {63'd0, stallOk}, 64'd1);
      checkOutput("mul_valid count", 64'(nMul), isDiv ? 64'd0 : 64'd1);
      checkOutput("div_valid count", 64'(nDiv), (isDiv && !spec) ? 64'd1 : 64'd0);
      checkOutput("flush pulse count", 64'(nFlush), toPath ? 64'd1 : 64'd0);
      if (!isDiv) checkOutput("mul_sign", {62'd0, sgn}, {62'd0, expSgn});
    end
    @(posedge clk);
    #1;
    ex_valid  = 1'b0;
    mul_ready = 1'b1;
    div_ready = 1'b1;
  endtask

  function automatic logic [63:0] randOperand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'hFFFF_FFFF_8000_0000;
      4:       return 64'h0000_0000_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin : stimulus
    int          cnt;
    logic [2:0]  opc;
    logic        w;
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_a = '0; ex_b = '0;
    mul_ready = 1'b1; div_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset res", res, 64'd0);
    checkOutput("reset res_valid", {63'd0, res_valid}, 64'd0);
    checkOutput("reset mul_valid", {63'd0, mul_valid}, 64'd0);
    checkOutput("reset div_valid", {63'd0, div_valid}, 64'd0);
    checkOutput("reset flushes", {62'd0, mul_flush, div_flush}, 64'd0);
    checkOutput("reset stall", {63'd0, stall}, 64'd0);
    checkOutput("reset mul_a", mul_a, 64'd0);
    checkOutput("reset div_b", div_b, 64'd0);
    rst = 1'b0;
    $display("[TB] reset released");

    applyStimulus(4'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 0, 4);
    applyStimulus(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 2);
    applyStimulus(4'b1100, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 3);
    applyStimulus(4'd7, 64'h1234_5678_9ABC_DEF0, 64'd0, 1, 3);
    applyStimulus(4'd5, 64'd100, 64'd7, 0, 5);
    applyStimulus(4'd4, 64'd1000, 64'd3, 0, 0);

    // Flush two cycles into DIV_WAIT.
    $display("[TB] flush during DIV_WAIT");
    divLat = 10;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = 4'd5; ex_a = 64'd100; ex_b = 64'd7;
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1; ex_valid = 1'b0;
    @(negedge clk);
    checkOutput("div_flush on flush", {63'd0, div_flush}, 64'd1);
    checkOutput("no res_valid on flush", {63'd0, res_valid}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (res_valid || div_flush || div_valid) cnt++;
    end
    checkOutput("quiet after flush", 64'(cnt), 64'd0);
    applyStimulus(4'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, 2);

    // Reset in the middle of MUL_WAIT; the late product must be ignored.
    $display("[TB] reset during MUL_WAIT");
    mulLat = 8;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_op = 4'd0; ex_a = 64'd5; ex_b = 64'd6;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; ex_valid = 1'b0;
    #1;
    checkOutput("rst res_valid", {63'd0, res_valid}, 64'd0);
    checkOutput("rst res", res, 64'd0);
    checkOutput("rst mul strobes", {62'd0, mul_valid, mul_flush}, 64'd0);
    checkOutput("rst mul_a", mul_a, 64'd0);
    checkOutput("rst mul_sign", {62'd0, mul_sign}, 64'd0);
    checkOutput("rst stall", {63'd0, stall}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid || mul_valid) cnt++;
    end
    checkOutput("late mul_out_valid ignored", 64'(cnt), 64'd0);

    $display("[TB] random ops");
    for (int i = 0; i < 40; i++) begin
      opc = 3'($urandom_range(0, 7));
      w = (opc == 3'd0 || opc[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
      applyStimulus({w, opc}, randOperand(), randOperand(),
                    $urandom_range(0, 3), $urandom_range(1, 5));
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
